// File: rtl/level_meter_pkg.sv
// Shared types and constants for the level meter: conversion FSM states and
// display scaling / BCD conversion sizes.
package level_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCALE   = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } meter_state_t;

    localparam int SCALE_FACTOR = 10000;
    localparam int MAX_DISPLAY  = 9999;
    localparam int BCD_DIGITS   = 4;
    localparam int BIN_W        = 14;

endpackage

// File: rtl/level_meter_bin2bcd_seq.sv
// Sequential double-dabble: BIN_W-bit binary to BCD_DIGITS packed BCD digits,
// one shift-add-3 iteration per clock after the start cycle.
module bin2bcd_seq
    import level_meter_pkg::*;
(
    input  logic                    clk_48,
    input  logic                    reset_n,
    input  logic                    i_start,
    input  logic [BIN_W-1:0]        i_bin,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [BCD_DIGITS*4-1:0] o_bcd
);

    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int IT_W  = $clog2(BIN_W + 1);

    logic [SR_W-1:0] r_sr;
    logic [SR_W-1:0] w_sr;
    logic [IT_W-1:0] r_iter;
    logic            r_busy;
    logic            r_done;

    assign w_sr[BIN_W-1:0] = r_sr[BIN_W-1:0];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [3:0] w_dig;
            assign w_dig = r_sr[BIN_W + gi*4 +: 4];
            assign w_sr[BIN_W + gi*4 +: 4] = (w_dig >= 4'd5) ? (w_dig + 4'd3) : w_dig;
        end
    endgenerate

    // Rotate rather than shift: the bit leaving the top is always zero for
    // in-range inputs, and the bits entering the binary half are never read.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_sr   <= '0;
            r_iter <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && !r_busy) begin
                r_sr   <= {{BCD_W{1'b0}}, i_bin};
                r_iter <= IT_W'(BIN_W);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_sr   <= {w_sr[SR_W-2:0], w_sr[SR_W-1]};
                r_iter <= r_iter - IT_W'(1);
                if (r_iter == IT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_sr[SR_W-1 -: BCD_W];

endmodule

// File: rtl/level_meter.sv
// Multi-channel windowed peak meter with hold, decay and sticky clip flags;
// the selected channel's held peak is shown as 4 BCD digits (per 10000 of FS).
module level_meter
    import level_meter_pkg::*;
#(
    parameter  int DATA_W       = 16,
    parameter  int NUM_CH       = 2,
    parameter  int WIN_LEN      = 4800,
    parameter  int HOLD_WINDOWS = 4,
    parameter  int DECAY_SHIFT  = 3,
    localparam int SEL_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk_48,
    input  logic                     reset_n,
    input  logic                     sample_valid,
    input  logic [NUM_CH*DATA_W-1:0] sample_in,
    input  logic [SEL_W-1:0]         ch_sel,
    output logic [3:0]               num3,
    output logic [3:0]               num2,
    output logic [3:0]               num1,
    output logic [3:0]               num0,
    output logic                     meter_valid,
    output logic [NUM_CH-1:0]        clip,
    output logic                     busy
);

    localparam int CNT_W  = $clog2(WIN_LEN);
    localparam int HC_W   = $clog2(HOLD_WINDOWS + 1);
    localparam int PROD_W = DATA_W + BIN_W;
    localparam logic [HC_W-1:0]   HOLD_CNT = HC_W'(HOLD_WINDOWS);
    localparam logic [DATA_W-1:0] CLIP_TH  = {1'b0, {(DATA_W-1){1'b1}}};

    logic [CNT_W-1:0]               r_win_cnt;
    logic                           w_window_done;
    logic [NUM_CH-1:0][DATA_W-1:0]  w_held;

    assign w_window_done = sample_valid && (r_win_cnt == CNT_W'(WIN_LEN - 1));

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n)
            r_win_cnt <= '0;
        else if (sample_valid)
            r_win_cnt <= w_window_done ? '0 : r_win_cnt + CNT_W'(1);
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [DATA_W-1:0] w_x;
            logic [DATA_W-1:0] w_mag;
            logic              w_sclip;
            logic [DATA_W-1:0] w_final;
            logic [DATA_W-1:0] w_decay;
            logic [DATA_W-1:0] r_win_peak;
            logic              r_win_clip;
            logic [DATA_W-1:0] r_held;
            logic [HC_W-1:0]   r_hold_cnt;
            logic [HC_W-1:0]   r_clip_cnt;

            assign w_x     = sample_in[gi*DATA_W +: DATA_W];
            assign w_mag   = w_x[DATA_W-1] ? ((~w_x) + DATA_W'(1)) : w_x;
            assign w_sclip = (w_mag >= CLIP_TH);
            // The window's last sample is folded in here, not via r_win_peak.
            assign w_final = (w_mag > r_win_peak) ? w_mag : r_win_peak;
            assign w_decay = r_held - (r_held >> DECAY_SHIFT);

            always_ff @(posedge clk_48 or negedge reset_n) begin
                if (!reset_n) begin
                    r_win_peak <= '0;
                    r_win_clip <= 1'b0;
                    r_held     <= '0;
                    r_hold_cnt <= '0;
                    r_clip_cnt <= '0;
                end else if (sample_valid) begin
                    if (w_window_done) begin
                        r_win_peak <= '0;
                        r_win_clip <= 1'b0;
                        if (w_final >= r_held) begin
                            r_held     <= w_final;
                            r_hold_cnt <= HOLD_CNT;
                        end else if (r_hold_cnt != '0) begin
                            r_hold_cnt <= r_hold_cnt - HC_W'(1);
                        end else begin
                            r_held <= (w_final > w_decay) ? w_final : w_decay;
                        end
                        if (r_win_clip || w_sclip)
                            r_clip_cnt <= HOLD_CNT;
                        else if (r_clip_cnt != '0)
                            r_clip_cnt <= r_clip_cnt - HC_W'(1);
                    end else begin
                        r_win_peak <= w_final;
                        r_win_clip <= r_win_clip | w_sclip;
                    end
                end
            end

            assign w_held[gi] = r_held;
            assign clip[gi]   = (r_clip_cnt != '0) | r_win_clip;
        end
    endgenerate

    logic [SEL_W-1:0]      w_sel;
    logic [PROD_W-1:0]     w_prod;
    logic [PROD_W-1:0]     w_shift;
    logic [BIN_W-1:0]      w_scaled;
    logic                  w_bcd_busy;
    logic                  w_bcd_done;
    logic [BCD_DIGITS*4-1:0] w_bcd;

    meter_state_t            r_state;
    logic [BCD_DIGITS*4-1:0] r_num;
    logic                    r_meter_valid;

    assign w_sel    = (int'(ch_sel) < NUM_CH) ? ch_sel : '0;
    assign w_prod   = w_held[w_sel] * BIN_W'(SCALE_FACTOR);
    assign w_shift  = w_prod >> (DATA_W - 1);
    assign w_scaled = (w_shift > PROD_W'(MAX_DISPLAY)) ? BIN_W'(MAX_DISPLAY) : w_shift[BIN_W-1:0];

    // ch_sel and the held peak are captured by the converter's start cycle.
    bin2bcd_seq u_bin2bcd (
        .clk_48  (clk_48),
        .reset_n (reset_n),
        .i_start (r_state == SCALE),
        .i_bin   (w_scaled),
        .o_busy  (w_bcd_busy),
        .o_done  (w_bcd_done),
        .o_bcd   (w_bcd)
    );

    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_num         <= '0;
            r_meter_valid <= 1'b0;
        end else begin
            r_meter_valid <= 1'b0;
            case (r_state)
                IDLE:    if (w_window_done) r_state <= SCALE;
                SCALE:   r_state <= CONVERT;
                CONVERT: if (w_bcd_done) r_state <= DONE;
                DONE: begin
                    r_num         <= w_bcd;
                    r_meter_valid <= 1'b1;
                    r_state       <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign num3        = r_num[15:12];
    assign num2        = r_num[11:8];
    assign num1        = r_num[7:4];
    assign num0        = r_num[3:0];
    assign meter_valid = r_meter_valid;
    assign busy        = (r_state != IDLE) | w_bcd_busy;

endmodule

// File: tb/tb_level_meter.sv
// Directed bench for level_meter: reset, basic conversion, saturation/clip
// hold, peak hold and decay, channel select, and reset during conversion.
module tb_level_meter;

    logic        clk_48 = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [31:0] sample_in = '0;
    logic [0:0]  ch_sel = '0;
    logic [3:0]  num3, num2, num1, num0;
    logic        meter_valid;
    logic [1:0]  clip;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int upd_cnt = 0;
    int upd_cycle = 0;
    logic [15:0] upd_val = '0;

    level_meter #(
        .DATA_W(16), .NUM_CH(2), .WIN_LEN(32), .HOLD_WINDOWS(2), .DECAY_SHIFT(3)
    ) dut (
        .clk_48      (clk_48),
        .reset_n     (reset_n),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .ch_sel      (ch_sel),
        .num3        (num3),
        .num2        (num2),
        .num1        (num1),
        .num0        (num0),
        .meter_valid (meter_valid),
        .clip        (clip),
        .busy        (busy)
    );

    always #5 clk_48 = ~clk_48;

    // Records every cycle meter_valid is seen high, with the edge index.
    always @(posedge clk_48) begin
        cyc = cyc + 1;
        #1;
        if (meter_valid === 1'b1) begin
            upd_cnt   = upd_cnt + 1;
            upd_cycle = cyc;
            upd_val   = {num3, num2, num1, num0};
        end
    end

    task automatic do_reset();
        sample_valid = 1'b0;
        sample_in    = '0;
        reset_n      = 1'b0;
        repeat (2) @(posedge clk_48);
        #1;
        reset_n = 1'b1;
    endtask

    // One full window, then an idle gap long enough for the conversion.
    task automatic do_window(input logic [15:0] a0, input logic [15:0] a1,
                             input int spike_idx, input logic [15:0] spike_val,
                             input int sel_at, input logic sel_val,
                             input logic [15:0] exp_bcd, input string name);
        int base;
        int last_edge;
        base = upd_cnt;
        for (int i = 0; i < 32; i++) begin
            if (i == sel_at) ch_sel = sel_val;
            sample_valid = 1'b1;
            sample_in    = {a1, (i == spike_idx) ? spike_val : a0};
            @(posedge clk_48);
            #1;
            if (i == spike_idx) begin
                checks++;
                if (clip[0] !== 1'b1) begin
                    failures++;
                    $display("FAIL %s clip_after_spike: got %b expected 1", name, clip[0]);
                end
            end
        end
        last_edge = cyc;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_start: got %b expected 1", name, busy);
        end
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (20) @(posedge clk_48);
        #1;
        checks++;
        if (upd_cnt - base !== 1) begin
            failures++;
            $display("FAIL %s valid_pulses: got %0d expected 1", name, upd_cnt - base);
        end
        checks++;
        if (upd_val !== exp_bcd) begin
            failures++;
            $display("FAIL %s display: got %h expected %h", name, upd_val, exp_bcd);
        end
        checks++;
        if (upd_cycle - last_edge !== 17) begin
            failures++;
            $display("FAIL %s latency: got %0d expected 17", name, upd_cycle - last_edge);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_end: got %b expected 0", name, busy);
        end
        $display("window %s: display=%h", name, upd_val);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample_in    = $urandom;
            sample_valid = 1'($urandom_range(0, 1));
            ch_sel       = 1'($urandom_range(0, 1));
            @(posedge clk_48);
            #1;
        end
        checks++;
        if ({num3, num2, num1, num0, meter_valid, clip, busy} !== 20'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h expected 0", {num3, num2, num1, num0, meter_valid, clip, busy});
        end
        sample_in = '0;
        ch_sel    = '0;
        reset_n   = 1'b1;
        sample_valid = 1'b1;
        repeat (20) @(posedge clk_48);
        #1;
        sample_valid = 1'b0;
        checks++;
        if ({num3, num2, num1, num0, clip, busy} !== 19'h0 || upd_cnt !== 0) begin
            failures++;
            $display("FAIL post_reset_idle: got %h upd=%0d expected 0 upd=0",
                     {num3, num2, num1, num0, clip, busy}, upd_cnt);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        do_reset();
        ch_sel = 1'b0;
        do_window(16'd16384, 16'd0, -1, 16'd0, -1, 1'b0, 16'h5000, "basic");
        checks++;
        if (clip !== 2'b00) begin
            failures++;
            $display("FAIL basic_clip: got %b expected 00", clip);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ch_sel = 1'b0;
        do_window(16'd0, 16'd0, 5, 16'h8000, -1, 1'b0, 16'h9999, "sat_w1");
        checks++;
        if (clip !== 2'b01) begin
            failures++;
            $display("FAIL sat_clip_w1: got %b expected 01", clip);
        end
        do_window(16'd0, 16'd0, -1, 16'd0, -1, 1'b0, 16'h9999, "sat_w2");
        checks++;
        if (clip !== 2'b01) begin
            failures++;
            $display("FAIL sat_clip_w2: got %b expected 01", clip);
        end
        do_window(16'd0, 16'd0, -1, 16'd0, -1, 1'b0, 16'h9999, "sat_w3");
        checks++;
        if (clip !== 2'b00) begin
            failures++;
            $display("FAIL sat_clip_w3: got %b expected 00", clip);
        end
    endtask

    task automatic test_hold_decay();
        logic [15:0] exp_seq [5];
        exp_seq = '{16'h5000, 16'h5000, 16'h5000, 16'h4375, 16'h3828};
        do_reset();
        ch_sel = 1'b0;
        for (int w = 0; w < 5; w++)
            do_window((w == 0) ? 16'd16384 : 16'd0, 16'd0, -1, 16'd0, -1, 1'b0,
                      exp_seq[w], $sformatf("decay_w%0d", w));
    endtask

    task automatic test_ch_sel();
        do_reset();
        ch_sel = 1'b1;
        do_window(16'd16384, 16'hE000, -1, 16'd0, -1, 1'b1, 16'h2500, "sel_ch1");
        do_window(16'd16384, 16'hE000, -1, 16'd0, 10, 1'b0, 16'h5000, "sel_switch");
    endtask

    task automatic test_reset_mid();
        int base;
        base = upd_cnt;
        ch_sel = 1'b0;
        for (int i = 0; i < 32; i++) begin
            sample_valid = 1'b1;
            sample_in    = {16'd0, 16'd16384};
            @(posedge clk_48);
            #1;
        end
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (5) @(posedge clk_48);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_busy_before: got %b expected 1", busy);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({num3, num2, num1, num0, meter_valid, busy} !== 18'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %h expected 0", {num3, num2, num1, num0, meter_valid, busy});
        end
        repeat (2) @(posedge clk_48);
        #1;
        reset_n = 1'b1;
        repeat (25) @(posedge clk_48);
        #1;
        checks++;
        if (upd_cnt !== base || {num3, num2, num1, num0} !== 16'h0) begin
            failures++;
            $display("FAIL mid_no_update: got upd=%0d num=%h expected upd=%0d num=0000",
                     upd_cnt - base, {num3, num2, num1, num0}, 0);
        end
        $display("reset_mid: aborted conversion checked");
        do_window(16'd8192, 16'd0, -1, 16'd0, -1, 1'b0, 16'h2500, "after_mid_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_hold_decay();
        test_ch_sel();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
